shift_arbiter: RTL and testbench
================================

// Module: shift_arbiter
// PURPOSE
//  - Shares one 8-bit shift datapath between N_REQ requesters. Round-robin arbitration,
//    valid/ready handshake on both sides, one registered result at a time.
//  - Sits in front of the shift unit. Clients issue {data, amount, op} and receive the
//    result tagged with their requester id.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  DATA_W   8   operand/result width; AMT_W=$clog2(DATA_W), ID_W=$clog2(N_REQ) are localparams
// PORTS
//  clk        in   1              clock; all logic on rising edge
//  rst        in   1              reset; synchronous, active-high
//  req_valid  in   N_REQ          per-requester request valid
//  req_data   in   N_REQ*DATA_W   operands, requester i at [i*DATA_W +: DATA_W]
//  req_amt    in   N_REQ*AMT_W    shift amounts, packed as above
//  req_op     in   N_REQ*2        op: 00 SLL, 01 SRL, 10 SRA, 11 ROR
//  req_ready  out  N_REQ          one-hot accept; a transfer occurs when valid&ready
//  res_valid  out  1              result valid
//  res_data   out  DATA_W         shifted result
//  res_id     out  ID_W           index of the requester that owns res_data
//  res_ready  in   1              result consumer ready
//  stat_grants out N_REQ*16       only with SHIFT_ARB_STATS_EN (see CONFIGURATION)
// BEHAVIOUR
//  - FSM states: IDLE (no result held) and BUSY (result held). res_valid = (state==BUSY).
//  - can_accept = (state==IDLE) | res_ready. When can_accept is high and any req_valid
//    is high, req_ready is high for exactly one winner in the same cycle (combinational).
//    Otherwise req_ready = 0.
//  - Arbitration is round-robin. ptr is the last granted index. Search order is
//    ptr+1 .. ptr+N_REQ mod N_REQ. ptr updates to the winner on each accept.
//  - On accept the core computes shift(data,amt,op); res_data and res_id register at the
//    edge, state goes to BUSY. Latency: accept edge -> res_valid on the next cycle.
//  - In BUSY with res_ready=1: a new accept in the same cycle stays BUSY with new data
//    (back-to-back, 1 result/cycle). With no request it goes to IDLE.
//  - In BUSY with res_ready=0: res_data and res_id are held stable and req_ready=0.
//  - Op rules: SLL/SRL zero-fill. SRA replicates the MSB. ROR is a rotate right.
//    amt=0 passes data through for every op.
//  - Requesters hold valid and payload stable until ready. The arbiter does not
//    re-check a dropped valid.
//  - Reset values: state=IDLE, res_valid=0, res_data=0, res_id=0, req_ready=0,
//    ptr=N_REQ-1 (requester 0 wins first). A reset mid-operation discards the held
//    result with no output.
//  - Simultaneous requests: exactly one is granted per accept cycle. The others wait.
//    Each active requester is granted within N_REQ accepts.
// CONFIGURATION
//  - SHIFT_ARB_STATS_EN defined: adds port stat_grants, with one 16-bit counter per
//    requester. A counter increments on that requester's accept and saturates at 16'hFFFF.
//    rst clears the counters.
//  - SHIFT_ARB_STATS_EN undefined: the port and counters are absent. Handshake timing
//    is identical in both builds.
// STRUCTURE
//  - shift_arb_pkg: op encoding enum (OP_SLL/OP_SRL/OP_SRA/OP_ROR), FSM state enum,
//    STAT_W=16.
//  - Sub-module shift_unit: purely combinational {data,amt,op}->result, parameterised
//    by DATA_W. The arbiter instantiates one. Arbiter, FSM and output registers live here.
// TESTING
//  1. Single req0: data 8'hFF, amt 4, SLL -> res_data 8'hF0, res_id 0, res_valid one
//     cycle after accept.
//  2. Ops on req1: SRL 8'hFF>>2 -> 8'h3F; SRA 8'h80 amt 7 -> 8'hFF; ROR 8'h81 amt 1 -> 8'hC0;
//     amt 0 any op -> input unchanged.
//  3. All 4 valid continuously, res_ready=1 -> grants in order 0,1,2,3,0,...;
//     one res_valid per cycle, res_id matches.
//  4. res_ready=0 for 5 cycles while BUSY -> res_data/res_id stable, req_ready all 0;
//     release -> next grant in the same cycle.
//  5. Assert rst while BUSY with res_ready=0 -> res_valid=0 next cycle;
//     after release req0 wins first.
//  6. With SHIFT_ARB_STATS_EN: 70000 grants to req2 -> stat_grants[2] = 16'hFFFF, the
//     other counters are correct. The bench is built both with and without the macro.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared types and constants for the shift arbiter
package shift_arb_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/shift_arbiter_shift_unit.sv
// rtl/shift_arbiter_shift_unit.sv - combinational shifter: SLL, SRL, SRA, ROR
module shift_unit
    import shift_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [AMT_W-1:0]  i_amt,
    input  logic [1:0]        i_op,
    output logic [DATA_W-1:0] o_res
);

    logic [2*DATA_W-1:0] w_rot;

    // Rotating a doubled copy keeps amt=0 well defined without a DATA_W-wide shift.
    assign w_rot = {i_data, i_data} >> i_amt;

    always_comb begin
        o_res = i_data;
        case (op_e'(i_op))
            OP_SLL:  o_res = i_data << i_amt;
            OP_SRL:  o_res = i_data >> i_amt;
            OP_SRA:  o_res = DATA_W'($signed(i_data) >>> i_amt);
            OP_ROR:  o_res = w_rot[DATA_W-1:0];
            default: o_res = i_data;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one shift unit among N_REQ clients
// Optional per-requester grant counters with SHIFT_ARB_STATS_EN.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     req_valid,
    input  logic [N_REQ*DATA_W-1:0]              req_data,
    input  logic [N_REQ*$clog2(DATA_W)-1:0]      req_amt,
    input  logic [N_REQ*2-1:0]                   req_op,
    output logic [N_REQ-1:0]                     req_ready,
    output logic                                 res_valid,
    output logic [DATA_W-1:0]                    res_data,
    output logic [$clog2(N_REQ)-1:0]             res_id,
    input  logic                                 res_ready
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0]              stat_grants
`endif
);

    localparam int AMT_W = $clog2(DATA_W);
    localparam int ID_W  = $clog2(N_REQ);

    state_e              r_state;
    logic [DATA_W-1:0]   r_res_data;
    logic [ID_W-1:0]     r_res_id;
    logic [ID_W-1:0]     r_ptr;

    logic                w_can_accept;
    logic                w_found;
    logic                w_accept;
    logic [ID_W-1:0]     w_win;
    logic [N_REQ-1:0]    w_grant;
    logic [DATA_W-1:0]   w_sel_data;
    logic [AMT_W-1:0]    w_sel_amt;
    logic [1:0]          w_sel_op;
    logic [DATA_W-1:0]   w_shift;

    // Distance d from the last winner picks the search order ptr+1 .. ptr+N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int d = 0; d < N_REQ; d++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!w_found && req_valid[j] &&
                    (((int'(r_ptr) + 1 + d) % N_REQ) == j)) begin
                    w_found = 1'b1;
                    w_win   = ID_W'(j);
                end
            end
        end
    end

    assign w_can_accept = (r_state == ST_IDLE) | res_ready;
    assign w_accept     = !rst & w_can_accept & w_found;
    assign w_grant      = w_accept ? (N_REQ'(1) << w_win) : '0;
    assign req_ready    = w_grant;

    assign w_sel_data = req_data[w_win*DATA_W +: DATA_W];
    assign w_sel_amt  = req_amt[w_win*AMT_W +: AMT_W];
    assign w_sel_op   = req_op[w_win*2 +: 2];

    shift_unit #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_shift (
        .i_data (w_sel_data),
        .i_amt  (w_sel_amt),
        .i_op   (w_sel_op),
        .o_res  (w_shift)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_res_data <= '0;
            r_res_id   <= '0;
            r_ptr      <= ID_W'(N_REQ - 1);
        end else begin
            if (w_accept) begin
                r_res_data <= w_shift;
                r_res_id   <= w_win;
                r_ptr      <= w_win;
            end
            case (r_state)
                ST_IDLE: if (w_accept) r_state <= ST_BUSY;
                ST_BUSY: if (res_ready && !w_accept) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign res_valid = (r_state == ST_BUSY);
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;

`ifdef SHIFT_ARB_STATS_EN
    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        logic [STAT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_grant[g] && (r_cnt != {STAT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign stat_grants[g*STAT_W +: STAT_W] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - self-checking bench for shift_arbiter (with or without SHIFT_ARB_STATS_EN)
module tb_shift_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*DW-1:0]  req_data;
    logic [N*AW-1:0]  req_amt;
    logic [N*2-1:0]   req_op;
    logic [N-1:0]     req_ready;
    logic             res_valid;
    logic [DW-1:0]    res_data;
    logic [IDW-1:0]   res_id;
    logic             res_ready;
`ifdef SHIFT_ARB_STATS_EN
    logic [N*16-1:0]  stat_grants;
`endif

    shift_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_op    (req_op),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] d;
        logic [2:0] amt;
        logic [1:0] op;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] d;
    } exp_t;

    vec_t       vecs[12];
    exp_t       sbq[$];
    logic [7:0] b_data[N];
    logic [2:0] b_amt[N];
    logic [1:0] b_op[N];
    int         m_ptr;
    bit         m_busy;
    int         m_cnt[N];
    logic [3:0] s_ready;
    int         n_checks;
    int         n_errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_shift(logic [7:0] d, logic [2:0] a, logic [1:0] op);
        logic [7:0] r;
        int s;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            case (op)
                2'd0: begin s = k - int'(a); r[k] = (s >= 0) ? d[s[2:0]] : 1'b0; end
                2'd1: begin s = k + int'(a); r[k] = (s < 8) ? d[s[2:0]] : 1'b0; end
                2'd2: begin s = k + int'(a); r[k] = (s < 8) ? d[s[2:0]] : d[7]; end
                default: begin s = (k + int'(a)) % 8; r[k] = d[s[2:0]]; end
            endcase
        end
        return r;
    endfunction

    function automatic int rr_pick(logic [N-1:0] v, int p);
        int k;
        for (int i = 1; i <= N; i++) begin
            k = (p + i) % N;
            if (v[k[IDW-1:0]]) return k;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = b_data[i];
            req_amt[i*AW +: AW]  = b_amt[i];
            req_op[i*2 +: 2]     = b_op[i];
        end
    endtask

    // Called at posedge+1 with inputs applied; checks at negedge, advances the model, returns at next posedge+1.
    task automatic cycle();
        int         w;
        bit         can;
        bit         acc;
        logic [3:0] er;
        #4;
        w   = rr_pick(req_valid, m_ptr);
        can = !m_busy || res_ready;
        acc = !rst && can && (w >= 0);
        er  = acc ? (4'b0001 << w) : 4'b0000;
        s_ready = req_ready;
        chk("req_ready", {60'd0, req_ready}, {60'd0, er});
        chk("res_valid", {63'd0, res_valid}, {63'd0, m_busy});
        if (m_busy) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_empty: got res_valid=%0b required no result", res_valid);
            end else begin
                chk("res_data", {56'd0, res_data}, {56'd0, sbq[0].d});
                chk("res_id", {62'd0, res_id}, {62'd0, sbq[0].id});
                if (res_ready) void'(sbq.pop_front());
            end
        end
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = N - 1;
            sbq.delete();
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (acc) begin
            sbq.push_back('{id: 2'(w), d: ref_shift(b_data[w], b_amt[w], b_op[w])});
            m_ptr  = w;
            m_busy = 1'b1;
            if (m_cnt[w] < 65535) m_cnt[w]++;
        end else if (m_busy && res_ready) begin
            m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] hold_d;
        logic [1:0] hold_id;

        vecs[0]  = '{0, 8'hFF, 3'd4, 2'd0, 8'hF0};
        vecs[1]  = '{1, 8'hFF, 3'd2, 2'd1, 8'h3F};
        vecs[2]  = '{1, 8'h80, 3'd7, 2'd2, 8'hFF};
        vecs[3]  = '{1, 8'h81, 3'd1, 2'd3, 8'hC0};
        vecs[4]  = '{1, 8'hA5, 3'd0, 2'd0, 8'hA5};
        vecs[5]  = '{1, 8'hA5, 3'd0, 2'd1, 8'hA5};
        vecs[6]  = '{1, 8'hA5, 3'd0, 2'd2, 8'hA5};
        vecs[7]  = '{1, 8'hA5, 3'd0, 2'd3, 8'hA5};
        vecs[8]  = '{2, 8'h96, 3'd3, 2'd2, 8'hF2};
        vecs[9]  = '{0, 8'h81, 3'd7, 2'd0, 8'h80};
        vecs[10] = '{3, 8'h96, 3'd3, 2'd3, 8'hD2};
        vecs[11] = '{3, 8'h81, 3'd7, 2'd1, 8'h01};

        n_checks = 0;
        n_errors = 0;
        m_ptr    = N - 1;
        m_busy   = 1'b0;
        for (int i = 0; i < N; i++) begin
            b_data[i] = '0;
            b_amt[i]  = '0;
            b_op[i]   = '0;
            m_cnt[i]  = 0;
        end
        rst       = 1'b1;
        req_valid = 4'hF;
        res_ready = 1'b1;
        drive();
        @(posedge clk);
        #1;
        cycle();
        chk("reset_res_data", {56'd0, res_data}, 64'd0);
        chk("reset_res_id", {62'd0, res_id}, 64'd0);
        rst       = 1'b0;
        req_valid = 4'h0;

        // Table of single transfers: one-cycle latency and op results
        for (int v = 0; v < 12; v++) begin
            b_data[vecs[v].id] = vecs[v].d;
            b_amt[vecs[v].id]  = vecs[v].amt;
            b_op[vecs[v].id]   = vecs[v].op;
            req_valid          = 4'b0001 << vecs[v].id;
            drive();
            cycle();
            req_valid = 4'h0;
            chk("vec_res_valid", {63'd0, res_valid}, 64'd1);
            chk("vec_res_data", {56'd0, res_data}, {56'd0, vecs[v].exp});
            chk("vec_res_id", {62'd0, res_id}, 64'(vecs[v].id));
            cycle();
        end

        // All requesters valid, back-to-back round robin
        for (int i = 0; i < N; i++) begin
            b_data[i] = 8'h3C + 8'(i * 17);
            b_amt[i]  = 3'(i + 1);
            b_op[i]   = 2'(i);
        end
        drive();
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk("rr_order", {60'd0, s_ready}, {60'd0, 4'b0001 << (k % 4)});
        end

        // Consumer stall: hold result, no grants; release grants in the same cycle
        res_ready = 1'b0;
        hold_d    = res_data;
        hold_id   = res_id;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_ready", {60'd0, s_ready}, 64'd0);
            chk("stall_data", {56'd0, res_data}, {56'd0, hold_d});
            chk("stall_id", {62'd0, res_id}, {62'd0, hold_id});
        end
        res_ready = 1'b1;
        cycle();
        chk("release_grant", {60'd0, s_ready}, 64'h1);
        req_valid = 4'h0;
        cycle();
        cycle();

`ifdef SHIFT_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk("stat_mid", {48'd0, stat_grants[i*16 +: 16]}, 64'(m_cnt[i]));
`endif

        // Reset while holding a stalled result
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'h0;
        res_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        req_valid = 4'hF;
        res_ready = 1'b1;
        cycle();
        chk("post_rst_grant", {60'd0, s_ready}, 64'h1);
        req_valid = 4'h0;
        cycle();
        cycle();

`ifdef SHIFT_ARB_STATS_EN
        // Saturate requester 2's counter
        req_valid = 4'b0100;
        for (int k = 0; k < 70000; k++) cycle();
        req_valid = 4'h0;
        cycle();
        cycle();
        chk("stat_sat2", {48'd0, stat_grants[2*16 +: 16]}, 64'hFFFF);
        for (int i = 0; i < N; i++)
            chk("stat_final", {48'd0, stat_grants[i*16 +: 16]}, 64'(m_cnt[i]));
`endif

        chk("sbq_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
